// File: rtl/pwm_fade_ctrl.sv
// PWM generator whose duty ramps up, holds at full scale, then ramps down to zero.
// Define FADE_LOOP_EN to restart the ramp-up after each fade-out (continuous breathing).
module pwm_fade_ctrl #(
    parameter int Width       = 17,
    parameter int Period      = 100000,
    parameter int StepPeriods = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [Width-1:0] step_i,
    input  logic [7:0]       hold_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] duty_o,
    output logic             tick_o,
    output logic             pwm_o
);
    localparam int SC_W = (StepPeriods > 1) ? $clog2(StepPeriods) : 1;
    localparam logic [Width-1:0] PERIOD_C  = Width'(Period);
    localparam logic [Width-1:0] LAST_CNT  = Width'(Period - 1);
    localparam logic [SC_W-1:0]  LAST_STEP = SC_W'(StepPeriods - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HOLD,
        S_DOWN,
        S_DONE
    } state_t;

    // Ramp arithmetic saturates at full scale / zero instead of wrapping.
    function automatic logic [Width-1:0] sat_up(input logic [Width-1:0] d,
                                                input logic [Width-1:0] s);
        logic [Width:0] sum;
        sum = {1'b0, d} + {1'b0, s};
        return (sum > {1'b0, PERIOD_C}) ? PERIOD_C : sum[Width-1:0];
    endfunction

    function automatic logic [Width-1:0] sat_down(input logic [Width-1:0] d,
                                                  input logic [Width-1:0] s);
        return (d > s) ? (d - s) : '0;
    endfunction

    state_t           state_q, state_d;
    logic [Width-1:0] cnt_q;
    logic [Width-1:0] duty_q, duty_d;
    logic [Width-1:0] step_q, step_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
    logic             done_q, done_d;
    logic             boundary;
    logic [Width-1:0] duty_up, duty_dn;

    assign tick_o   = (cnt_q == LAST_CNT);
    assign boundary = tick_o && (step_cnt_q == LAST_STEP);
    assign duty_up  = sat_up(duty_q, step_q);
    assign duty_dn  = sat_down(duty_q, step_q);
    assign busy_o   = (state_q == S_UP) || (state_q == S_HOLD) || (state_q == S_DOWN);
    assign done_o   = done_q;
    assign duty_o   = duty_q;
    assign pwm_o    = (cnt_q < duty_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            step_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= tick_o ? '0 : cnt_q + Width'(1);
            duty_q     <= duty_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            step_cnt_q <= step_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        if (tick_o) step_cnt_d = boundary ? '0 : step_cnt_q + SC_W'(1);

        case (state_q)
            S_IDLE: begin
                duty_d = '0;
                if (start_i) begin
                    step_d     = (step_i == '0) ? Width'(1) : step_i;
                    hold_d     = hold_i;
                    step_cnt_d = '0;
                    state_d    = S_UP;
                end
            end
            S_UP: begin
                if (stop_i) begin
                    duty_d  = '0;
                    state_d = S_IDLE;
                end else if (boundary) begin
                    duty_d = duty_up;
                    if (duty_up == PERIOD_C) begin
                        hold_cnt_d = '0;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                duty_d = PERIOD_C;
                if (stop_i) begin
                    duty_d  = '0;
                    state_d = S_IDLE;
                end else if (tick_o) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    // A zero hold still spends one full period at 100%.
                    if (({1'b0, hold_cnt_q} + 9'd1) >= {1'b0, hold_q}) begin
                        step_cnt_d = '0;
                        state_d    = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                if (stop_i) begin
                    duty_d  = '0;
                    state_d = S_IDLE;
                end else if (boundary) begin
                    duty_d = duty_dn;
                    if (duty_dn == '0) begin
                        done_d = 1'b1;
`ifdef FADE_LOOP_EN
                        step_cnt_d = '0;
                        state_d    = S_UP;
`else
                        state_d    = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                duty_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                duty_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed plus randomized bench for pwm_fade_ctrl against a queue-based fade-profile model.
module tb_pwm_fade_ctrl;
    localparam int W  = 17;
    localparam int P  = 10;
    localparam int SP = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] step_v = '0;
    logic [7:0]   hold_v = '0;
    logic         busy_o, done_o, tick_o, pwm_o;
    logic [W-1:0] duty_o;

    pwm_fade_ctrl #(.Width(W), .Period(P), .StepPeriods(SP)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .stop_i  (stop),
        .step_i  (step_v),
        .hold_i  (hold_v),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .duty_o  (duty_o),
        .tick_o  (tick_o),
        .pwm_o   (pwm_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: period position, displayed duty, and the queue of duty values still to come, one per tick.
    int m_cnt = 0;
    int m_duty = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_prof[$];
    int m_base[$];

    task automatic build_profile(input int s, input int h);
        int eff;
        int d;
        m_base.delete();
        eff = (s == 0) ? 1 : s;
        d = 0;
        do begin
            d = (d + eff > P) ? P : d + eff;
            m_base.push_back(d);
        end while (d < P);
        for (int i = 0; i < ((h == 0) ? 1 : h); i++) m_base.push_back(P);
        do begin
            d = (d > eff) ? d - eff : 0;
            m_base.push_back(d);
        end while (d > 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit was_tick;
        bit idle;
        @(posedge clk);
        was_tick = (m_cnt == P - 1);
        idle     = !m_busy && !m_done;
        m_done   = 1'b0;
        if (rst) begin
            m_cnt  = 0;
            m_duty = 0;
            m_busy = 1'b0;
            m_prof.delete();
        end else begin
            if (m_busy) begin
                if (stop) begin
                    m_duty = 0;
                    m_busy = 1'b0;
                    m_prof.delete();
                end else if (was_tick) begin
                    m_duty = m_prof.pop_front();
                    if (m_prof.size() == 0) begin
                        m_done = 1'b1;
`ifdef FADE_LOOP_EN
                        m_prof = m_base;
`else
                        m_busy = 1'b0;
`endif
                    end
                end
            end else if (idle && start) begin
                build_profile(int'(step_v), int'(hold_v));
                m_prof = m_base;
                m_busy = 1'b1;
            end
            m_cnt = was_tick ? 0 : m_cnt + 1;
        end
        #1;
        chk("duty", duty_o, m_duty);
        chk("pwm", pwm_o, (m_cnt < m_duty));
        chk("tick", tick_o, (m_cnt == P - 1));
        chk("busy", busy_o, m_busy);
        chk("done", done_o, m_done);
    endtask

    task automatic wait_for_done(input int limit);
        int n = 0;
        while (done_o !== 1'b1 && n < limit) begin
            cycle();
            n++;
        end
        chk("done_reached", done_o, 1);
    endtask

    task automatic wait_for_duty(input int val, input int limit);
        int n = 0;
        while (duty_o !== W'(val) && n < limit) begin
            cycle();
            n++;
        end
        chk("duty_reached", duty_o, val);
    endtask

    // Called on the done cycle: a start here must be ignored; loop builds then breathe once more and stop.
    task automatic end_seq();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
`ifdef FADE_LOOP_EN
        repeat (250) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (3) cycle();
`endif
    endtask

    initial begin
        int hi;
        int wait_n;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (13) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        step_v = W'(4);
        hold_v = 8'd2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_duty(4, 40);
        hi = int'(pwm_o);
        repeat (9) begin
            cycle();
            hi += int'(pwm_o);
        end
        chk("pwm_high_count", hi, 4);
        wait_for_done(200);
        end_seq();

        step_v = W'(3);
        hold_v = 8'd5;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_duty(P, 80);
        repeat (12) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (50) cycle();

        step_v = W'(0);
        hold_v = 8'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (30) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_done(300);
        end_seq();

        step_v = W'(5);
        hold_v = 8'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_done(100);
        end_seq();

        step_v = W'(2);
        hold_v = 8'd1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (25) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) cycle();

        step_v = W'(7);
        hold_v = 8'd1;
        start = 1'b1;
        stop = 1'b1;
        cycle();
        start = 1'b0;
        stop = 1'b0;
        wait_for_done(200);
        end_seq();

        repeat (8) begin
            step_v = W'($urandom_range(0, 12));
            hold_v = 8'($urandom_range(0, 3));
            start = 1'b1;
            cycle();
            start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                wait_n = $urandom_range(1, 150);
                repeat (wait_n) cycle();
                stop = 1'b1;
                cycle();
                stop = 1'b0;
                repeat (3) cycle();
            end else begin
                wait_for_done(400);
                end_seq();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
